// File: rtl/frogger_pkg.sv
// Shared constants, state encoding and spawn-point helpers for the road-crossing game.
package frogger_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int COORD_W   = 10;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'b00,
        ST_HIT       = 2'b01,
        ST_GAME_OVER = 2'b10
    } state_e;

    function automatic logic [COORD_W-1:0] spawn_x(input int h_disp, input int pw);
        return COORD_W'(h_disp / 2 - pw / 2);
    endfunction

    function automatic logic [COORD_W-1:0] spawn_y(input int v_disp, input int ph, input int step);
        return COORD_W'(v_disp - ph - step);
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational strict-overlap test between rectangle A (player) and rectangle B (car).
module aabb_overlap
    import frogger_pkg::*;
#(
    parameter int A_W = 32,
    parameter int A_H = 32,
    parameter int B_W = 64,
    parameter int B_H = 32
) (
    input  logic [COORD_W-1:0] ax_i,
    input  logic [COORD_W-1:0] ay_i,
    input  logic [COORD_W-1:0] bx_i,
    input  logic [COORD_W-1:0] by_i,
    output logic               hit_o
);

    // One extra bit so edge sums near the top of the coordinate range cannot wrap.
    logic [COORD_W:0] ax, ay, bx, by;

    assign ax = {1'b0, ax_i};
    assign ay = {1'b0, ay_i};
    assign bx = {1'b0, bx_i};
    assign by = {1'b0, by_i};

    assign hit_o = (ax < bx + (COORD_W+1)'(B_W)) &&
                   (bx < ax + (COORD_W+1)'(A_W)) &&
                   (ay < by + (COORD_W+1)'(B_H)) &&
                   (by < ay + (COORD_W+1)'(A_H));

endmodule

// File: rtl/player_controller.sv
// Player movement, collision/respawn, lives, score and game-over handling on a STEP-pixel grid.
module player_controller #(
    parameter int H_DISPLAY      = frogger_pkg::H_DISPLAY,
    parameter int V_DISPLAY      = frogger_pkg::V_DISPLAY,
    parameter int PLAYER_WIDTH   = 32,
    parameter int PLAYER_HEIGHT  = 32,
    parameter int STEP           = 32,
    parameter int MOVE_COOLDOWN  = 2500000,
    parameter int NUM_CARS       = 4,
    parameter int CAR_WIDTH      = 64,
    parameter int CAR_HEIGHT     = 32,
    parameter int LIVES          = 3,
    parameter int RESPAWN_CYCLES = 12500000,
    parameter int GOAL_Y         = 0,
    parameter int SCORE_W        = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SW1,
    input  logic                  SW2,
    input  logic                  SW3,
    input  logic                  SW4,
    input  logic [10*NUM_CARS-1:0] car_x_bus,
    input  logic [10*NUM_CARS-1:0] car_y_bus,
    output logic [9:0]            player_x,
    output logic [9:0]            player_y,
    output logic [3:0]            lives,
    output logic [SCORE_W-1:0]    score,
    output logic [1:0]            state,
    output logic                  hit_pulse,
    output logic                  win_pulse
);
    import frogger_pkg::*;

    localparam int CW     = COORD_W;
    localparam int COOL_W = $clog2(MOVE_COOLDOWN + 1);
    localparam int TMR_W  = $clog2(RESPAWN_CYCLES + 1);
    localparam logic [CW-1:0]     SPAWN_X  = spawn_x(H_DISPLAY, PLAYER_WIDTH);
    localparam logic [CW-1:0]     SPAWN_Y  = spawn_y(V_DISPLAY, PLAYER_HEIGHT, STEP);
    localparam logic [COOL_W-1:0] COOL_MAX = COOL_W'(MOVE_COOLDOWN);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(RESPAWN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      x_q, x_d, y_q, y_d;
    logic [3:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COOL_W-1:0]  cool_q, cool_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               hit_q, hit_d, win_q, win_d, sw1_q;

    logic [NUM_CARS-1:0] car_hit;
    logic                collide, up_ok, down_ok, left_ok, right_ok, moved;

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        aabb_overlap #(
            .A_W(PLAYER_WIDTH), .A_H(PLAYER_HEIGHT), .B_W(CAR_WIDTH), .B_H(CAR_HEIGHT)
        ) u_aabb (
            .ax_i(x_q), .ay_i(y_q),
            .bx_i(car_x_bus[10*i +: 10]), .by_i(car_y_bus[10*i +: 10]),
            .hit_o(car_hit[i])
        );
    end

    assign collide  = |car_hit;
    assign up_ok    = {1'b0, y_q} >= (CW+1)'(STEP);
    assign down_ok  = {1'b0, y_q} + (CW+1)'(STEP) <= (CW+1)'(V_DISPLAY - PLAYER_HEIGHT);
    assign left_ok  = {1'b0, x_q} >= (CW+1)'(STEP);
    assign right_ok = {1'b0, x_q} + (CW+1)'(STEP) <= (CW+1)'(H_DISPLAY - PLAYER_WIDTH);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_PLAY;
            x_q     <= SPAWN_X;
            y_q     <= SPAWN_Y;
            lives_q <= 4'(LIVES);
            score_q <= '0;
            cool_q  <= COOL_MAX;
            timer_q <= '0;
            hit_q   <= 1'b0;
            win_q   <= 1'b0;
            sw1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lives_q <= lives_d;
            score_q <= score_d;
            cool_q  <= cool_d;
            timer_q <= timer_d;
            hit_q   <= hit_d;
            win_q   <= win_d;
            sw1_q   <= SW1;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lives_d = lives_q;
        score_d = score_q;
        cool_d  = (cool_q == COOL_MAX) ? cool_q : cool_q + COOL_W'(1);
        timer_d = timer_q;
        hit_d   = 1'b0;
        win_d   = 1'b0;
        moved   = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (collide) begin
                    hit_d   = 1'b1;
                    lives_d = lives_q - 4'd1;
                    x_d     = SPAWN_X;
                    y_d     = SPAWN_Y;
                    timer_d = '0;
                    state_d = (lives_q == 4'd1) ? ST_GAME_OVER : ST_HIT;
                end else if (y_q == CW'(GOAL_Y)) begin
                    win_d   = 1'b1;
                    score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    x_d     = SPAWN_X;
                    y_d     = SPAWN_Y;
                    cool_d  = '0;
                end else if (cool_q == COOL_MAX) begin
                    // A blocked button falls through to the next one in priority order.
                    moved = 1'b1;
                    if (SW1 && up_ok)         y_d = y_q - CW'(STEP);
                    else if (SW2 && down_ok)  y_d = y_q + CW'(STEP);
                    else if (SW3 && left_ok)  x_d = x_q - CW'(STEP);
                    else if (SW4 && right_ok) x_d = x_q + CW'(STEP);
                    else                      moved = 1'b0;
                    if (moved) cool_d = '0;
                end
            end
            ST_HIT: begin
                x_d = SPAWN_X;
                y_d = SPAWN_Y;
                if (timer_q == TMR_LAST) begin
                    state_d = ST_PLAY;
                    timer_d = '0;
                    cool_d  = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_GAME_OVER: begin
                x_d = SPAWN_X;
                y_d = SPAWN_Y;
                if (SW1 && !sw1_q) begin
                    lives_d = 4'(LIVES);
                    score_d = '0;
                    state_d = ST_PLAY;
                    cool_d  = '0;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    assign player_x  = x_q;
    assign player_y  = y_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign state     = state_q;
    assign hit_pulse = hit_q;
    assign win_pulse = win_q;

endmodule
